pipe_reg_chain: RTL and testbench

Parametrised elastic pipeline-register chain; successor to the single-stage stall-only pipeline register. Holds DEPTH stages of WIDTH-bit payload, each with a valid bit. Adds valid/ready handshake with bubble collapsing, global flush, occupancy count and per-stage clock gating. Sits between core stages where back-pressure and squash on mispredict/exception must be absorbed without a separate FIFO.

---
 rtl/pipe_pkg.sv | 9 +
 rtl/pipe_stage_cell.sv | 74 +++++++
 rtl/pipe_reg_chain.sv | 95 +++++++++
 tb/tb_pipe_reg_chain.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared helpers for the elastic pipeline-register chain.
package pipe_pkg;

    // Width needed to count 0..depth valid stages.
    function automatic int cnt_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// One chain stage: valid flop on the core clock, payload flop optionally on a gated clock,
// plus the latch-based clock gater used for that payload flop.
module clk_gater_ul (
    input  logic clk,
    input  logic en,
    output logic gclk
);
    logic en_lat;

    // Transparent-low latch keeps the enable glitch-free while clk is high.
    always_latch begin
        if (!clk) begin
            en_lat <= en;
        end
    end

    assign gclk = clk & en_lat;
endmodule

module pipe_stage_cell #(
    parameter int WIDTH   = 32,
    parameter int CLKGATE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic             poison,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);
    logic data_clk;

    generate
        if (CLKGATE != 0) begin : g_gate
            clk_gater_ul u_cg (
                .clk  (clk),
                .en   (load | poison),
                .gclk (data_clk)
            );
        end else begin : g_plain
            assign data_clk = clk;
        end
    endgenerate

    // A load wins over a clear so a stage refilled while draining stays valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end else begin
            valid <= valid;
        end
    end

    // Payload only changes on load; loss of power scrambles it in simulation builds.
    always_ff @(posedge data_clk or posedge reset) begin
        if (reset) begin
            q <= {WIDTH{1'b0}};
        end else if (load) begin
            q <= d;
`ifdef SIM
        end else if (poison) begin
            q <= {WIDTH{1'bx}};
`endif
        end else begin
            q <= q;
        end
    end
endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage pipeline register with valid/ready handshake, bubble collapsing,
// flush, power-loss squash and occupancy tracking.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 2,
    parameter int CLKGATE = 1,
    parameter int CNT_W   = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             clkEn_i,
    input  logic             pwrEn_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [CNT_W-1:0] occupancy_o,
    input  logic             pwr_unused_tie = 1'b0,
    output logic             empty_o
);
    logic             hold;
    logic             kill;
    logic             go;
    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH:0]   move;
    logic [DEPTH-1:0] adv;
    logic             in_rdy;
    logic [CNT_W-1:0] occ_r;

    assign hold = stall_i | ~clkEn_i;
    assign kill = flush_i | ~pwrEn_i;
    assign go   = ~hold & ~kill;

    // Ready ripples from the head toward the tail so empty stages absorb bubbles.
    always_comb begin
        move        = {(DEPTH + 1){1'b0}};
        adv         = {DEPTH{1'b0}};
        move[DEPTH] = valid[DEPTH-1] & go & out_ready_i;
        for (int i = DEPTH - 1; i >= 1; i--) begin
            adv[i]  = ~valid[i] | move[i+1];
            move[i] = valid[i-1] & adv[i] & go;
        end
        adv[0]  = ~valid[0] | move[1];
        in_rdy  = adv[0] & go & ~reset;
        move[0] = in_valid_i & in_rdy;
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_stage
            logic [WIDTH-1:0] src;
            if (g == 0) begin : g_tail
                assign src = in_data_i;
            end else begin : g_body
                assign src = data[g-1];
            end
            pipe_stage_cell #(
                .WIDTH   (WIDTH),
                .CLKGATE (CLKGATE)
            ) u_cell (
                .clk    (clk),
                .reset  (reset),
                .load   (move[g]),
                .clear  (kill | move[g+1]),
                .poison (~pwrEn_i),
                .d      (src),
                .valid  (valid[g]),
                .q      (data[g])
            );
        end
    endgenerate

    // Occupancy tracks net entries; kill empties the chain outright.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_r <= {CNT_W{1'b0}};
        end else if (kill) begin
            occ_r <= {CNT_W{1'b0}};
        end else begin
            occ_r <= occ_r + CNT_W'(move[0]) - CNT_W'(move[DEPTH]);
        end
    end

    assign in_ready_o  = in_rdy;
    assign out_valid_o = valid[DEPTH-1] & go;
    assign out_data_o  = data[DEPTH-1];
    assign occupancy_o = occ_r;
    assign empty_o     = (occ_r == {CNT_W{1'b0}});
endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed self-checking bench for pipe_reg_chain at DEPTH=3, WIDTH=8 with clock gating.
module tb_pipe_reg_chain;
    logic       clk = 1'b0;
    logic       reset;
    logic       stall, flush, clk_en, pwr_en;
    logic       in_valid, in_ready, out_valid, out_ready, empty;
    logic [7:0] in_data, out_data;
    logic [1:0] occupancy;
    int         checks = 0;
    int         errors = 0;

    pipe_reg_chain #(.WIDTH(8), .DEPTH(3), .CLKGATE(1)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_i        (stall),
        .flush_i        (flush),
        .clkEn_i        (clk_en),
        .pwrEn_i        (pwr_en),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_data_i      (in_data),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_data_o     (out_data),
        .occupancy_o    (occupancy),
        .pwr_unused_tie (1'b0),
        .empty_o        (empty)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        in_valid = 1'b1;
        in_data  = v;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        push(8'hC1);
        push(8'hC2);
        cyc();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL mid_occ_before: got %0d want 2", occupancy); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hC1) begin errors++; $display("FAIL mid_head_before: got %b/%h want 1/c1", out_valid, out_data); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        checks++; if (occupancy !== 2'd0 || empty !== 1'b1) begin errors++; $display("FAIL mid_occ: got %0d/%b want 0/1", occupancy, empty); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL mid_out_data: got %h want 00", out_data); end
        #1;
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_stream;
        logic [7:0] vals [4];
        logic [1:0] occ_exp [8];
        vals    = '{8'h11, 8'h22, 8'h33, 8'h44};
        occ_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                in_valid = 1'b1;
                in_data  = vals[k];
            end else begin
                in_valid = 1'b0;
                in_data  = 8'h00;
            end
            #1;
            if (k < 4) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", k, in_ready); end
            end
            cyc();
            checks++; if (occupancy !== occ_exp[k]) begin errors++; $display("FAIL stream_occ[%0d]: got %0d want %0d", k, occupancy, occ_exp[k]); end
            checks++; if (out_valid !== ((k >= 2) && (k <= 5))) begin errors++; $display("FAIL stream_out_valid[%0d]: got %b", k, out_valid); end
            if ((k >= 2) && (k <= 5)) begin
                checks++; if (out_data !== vals[k-2]) begin errors++; $display("FAIL stream_out_data[%0d]: got %h want %h", k, out_data, vals[k-2]); end
            end
        end
    endtask

    task automatic test_collapse;
        out_ready = 1'b0;
        push(8'hA1);
        cyc(); cyc(); cyc();
        push(8'hA2);
        cyc();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL collapse_occ: got %0d want 2", occupancy); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA1) begin errors++; $display("FAIL collapse_head: got %b/%h want 1/a1", out_valid, out_data); end
        in_valid = 1'b1;
        in_data  = 8'hA3;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL collapse_ready_open: got %b want 1", in_ready); end
        cyc();
        checks++; if (occupancy !== 2'd3) begin errors++; $display("FAIL collapse_occ_full: got %0d want 3", occupancy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL collapse_ready_full: got %b want 0", in_ready); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        checks++; if (out_data !== 8'hA2) begin errors++; $display("FAIL collapse_pop2: got %h want a2", out_data); end
        cyc();
        checks++; if (out_data !== 8'hA3) begin errors++; $display("FAIL collapse_pop3: got %h want a3", out_data); end
        cyc();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL collapse_drained: got %b want 1", empty); end
    endtask

    task automatic test_stall;
        out_ready = 1'b0;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        checks++; if (occupancy !== 2'd3) begin errors++; $display("FAIL stall_fill: got %0d want 3", occupancy); end
        in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_blocked: got %b want 0", in_ready); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        stall     = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_hs: got %b/%b want 0/0", out_valid, in_ready); end
        cyc();
        cyc();
        checks++; if (occupancy !== 2'd3 || out_valid !== 1'b0) begin errors++; $display("FAIL stall_hold: got %0d/%b want 3/0", occupancy, out_valid); end
        stall = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin errors++; $display("FAIL stall_release: got %b/%h want 1/01", out_valid, out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_passthru_ready: got %b want 1", in_ready); end
        cyc();
        checks++; if (out_data !== 8'h02 || occupancy !== 2'd2) begin errors++; $display("FAIL stall_pop: got %h/%0d want 02/2", out_data, occupancy); end
        clk_en = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clken_out_valid: got %b want 0", out_valid); end
        cyc();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL clken_occ: got %0d want 2", occupancy); end
        clk_en = 1'b1;
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        push(8'h04);
        checks++; if (occupancy !== 2'd3) begin errors++; $display("FAIL flush_fill: got %0d want 3", occupancy); end
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_hs: got %b/%b want 0/0", in_ready, out_valid); end
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (occupancy !== 2'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_occ: got %0d/%b want 0/1", occupancy, empty); end
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_after: got %b/%b want 1/0", in_ready, out_valid); end
        checks++; if (out_data !== 8'h02) begin errors++; $display("FAIL flush_data_kept: got %h want 02", out_data); end
        cyc(); cyc(); cyc();
        checks++; if (out_valid !== 1'b0 || out_data === 8'hFF) begin errors++; $display("FAIL flush_ff_dropped: got %b/%h want 0/not ff", out_valid, out_data); end
    endtask

    task automatic test_power;
        out_ready = 1'b0;
        push(8'hB1);
        push(8'hB2);
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL pwr_fill: got %0d want 2", occupancy); end
        pwr_en = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pwr_in_ready: got %b want 0", in_ready); end
        cyc();
        pwr_en = 1'b1;
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL pwr_cleared: got %0d/%b want 0/0", occupancy, out_valid); end
`ifdef SIM
        checks++; if (!$isunknown(out_data)) begin errors++; $display("FAIL pwr_data_x: got %h want x", out_data); end
`endif
        out_ready = 1'b1;
        push(8'h5A);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pwr_lat1: got %b want 0", out_valid); end
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pwr_lat2: got %b want 0", out_valid); end
        cyc();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin errors++; $display("FAIL pwr_5a_out: got %b/%h want 1/5a", out_valid, out_data); end
        cyc();
        checks++; if (empty !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL pwr_drain: got %b/%b want 1/0", empty, out_valid); end
    endtask

    initial begin
        reset     = 1'b1;
        stall     = 1'b0;
        flush     = 1'b0;
        clk_en    = 1'b1;
        pwr_en    = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        test_reset();
        test_reset_mid();
        test_stream();
        test_collapse();
        test_stall();
        test_flush();
        test_power();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
